mmio_responder: RTL
===================

Name: mmio_responder

Overview:
- Memory-mapped peripheral that answers the CPU's data load/store port, alongside ram, for a one-page address window.
- Provides a console TX byte FIFO drained through a valid/ready stream, a free-running machine timer with compare interrupt, and a scratch register.
- Loads are combinational, so a single-cycle core sees data in the same cycle. Stores commit on the clock edge.

Parameters:
BASE  32'h1000_0000  window base; the window is selected when address_i[31:8] == BASE[31:8]
FIFO_DEPTH  8  TX FIFO entries; power of two, >= 2

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
address_i  in  32  byte address from the CPU load/store unit
unsigned_i  in  1  load zero-extends when 1 and sign-extends when 0
size_i  in  2  00 byte, 01 half, 10 word; 11 is invalid (load returns 0, store ignored)
data_i  in  32  store data, right-aligned
wr_enable_i  in  1  store strobe, sampled at posedge clock
output_o  out  32  load data (combinational)
tx_valid_o  out  1  FIFO non-empty
tx_data_o  out  8  FIFO head byte (first-word-fall-through)
tx_ready_i  in  1  sink accepts the head byte when tx_valid_o && tx_ready_i
timer_irq_o  out  1  high when mtime >= mtimecmp (unsigned)

Behaviour:
Register map (offset = address_i[7:0]):
- 0x00 TXDATA
  - Store of any valid aligned size pushes data_i[7:0].
  - Reads as 0.
- 0x04 STATUS (read-only except bit2)
  - bit0 full, bit1 empty, bit2 overflow (sticky), [15:8] count, other bits 0.
  - Store with data_i[2]=1 clears overflow.
- 0x08 MTIME: R/W, increments by 1 every cycle.
- 0x0C MTIMECMP: R/W.
- 0x10 SCRATCH: R/W.
- Other offsets, or addresses outside the window: read 0, stores ignored.

Access rules:
- Alignment:
  - Half requires address_i[0]=0.
  - Word requires address_i[1:0]=0.
  - A misaligned access reads 0, and its store is ignored with no side effect.
- Sub-word stores to MTIME, MTIMECMP and SCRATCH update only the addressed byte or half lanes: byte lane = address_i[1:0], half lane = address_i[1].
- Sub-word loads extract the lane, then zero- or sign-extend per unsigned_i.

FIFO:
- Push is accepted only if count < FIFO_DEPTH at the edge. This holds even if a pop happens in the same cycle.
- A push while full is dropped and sets overflow.
- Pop occurs when tx_valid_o && tx_ready_i.
- Push and pop in the same cycle (not full): count is unchanged and ordering is preserved.
- Pointers wrap modulo FIFO_DEPTH; count is $clog2(FIFO_DEPTH)+1 bits wide.
- tx_data_o is don't-care when empty, but must be stable while tx_valid_o is high and not popped.
- If an overflow-clear and an overflowing push land in the same cycle, set wins.

Timer:
- mtime wraps from 32'hFFFF_FFFF to 0.
- A store to MTIME in a cycle overrides that cycle's increment. The written lanes take data_i; unwritten lanes take the current value + 1 on the same lanes.
- Implementation: compute next = mtime + 1, then merge in the written lanes.
- timer_irq_o is a combinational compare of the current registers. It holds as a level until software moves mtimecmp or mtime.

Reset (synchronous):
- mtime = 0, mtimecmp = 32'hFFFF_FFFF, scratch = 0.
- FIFO empty, overflow = 0.
- Resulting outputs: tx_valid_o = 0, timer_irq_o = 0, output_o reflects the reset register values.
- Reset asserted mid-drain discards FIFO contents. A pop and a push in the reset cycle have no effect.

Test Plan:
1. Reset, then read STATUS (word, 0x04) -> output_o = 32'h0000_0002. timer_irq_o = 0. MTIME reads increase by 1 per cycle from 0.
2. tx_ready_i=0; push 0x41..0x49 (9 byte stores to 0x00), FIFO_DEPTH=8 -> STATUS = 32'h0000_0805 (count 8, full, overflow). Raise tx_ready_i -> tx_data_o = 0x41..0x48 in order, then tx_valid_o drops.
3. Full FIFO with a push and a pop in the same cycle -> push is dropped, count becomes 7, overflow is set. A STATUS store of 32'h4 clears it -> STATUS bit2 = 0.
4. Write MTIMECMP=20, MTIME=15 -> timer_irq_o rises exactly 5 cycles after the MTIME write. Write MTIME=32'hFFFF_FFFF, then one cycle later -> reads 0.
5. SCRATCH=32'h8081_7F80. Byte load at 0x11 signed -> 32'h0000_007F. Byte load at 0x13 signed -> 32'hFFFF_FF80. Half load at 0x12 unsigned -> 32'h0000_8081. Misaligned half load at 0x11 -> 0.
6. Half store 32'hBEEF to 0x12 over SCRATCH=0 -> SCRATCH = 32'hBEEF_0000. Word store to 0x20, and to address BASE+32'h100 -> no register change, reads 0.

Source files
------------

// File: rtl/mmio_responder.sv
// mmio_responder: one-page memory-mapped peripheral on the CPU load/store port.
// Holds a console TX byte FIFO (valid/ready drain), a free-running machine timer
// with a compare interrupt, and a scratch register. Loads are combinational and
// stores commit on the rising clock edge.
module mmio_responder #(
  parameter logic [31:0] BASE       = 32'h1000_0000,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address_i,
  input  logic        unsigned_i,
  input  logic [1:0]  size_i,
  input  logic [31:0] data_i,
  input  logic        wr_enable_i,
  output logic [31:0] output_o,
  output logic        tx_valid_o,
  output logic [7:0]  tx_data_o,
  input  logic        tx_ready_i,
  output logic        timer_irq_o
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  localparam logic [5:0] REG_TXDATA   = 6'h00;
  localparam logic [5:0] REG_STATUS   = 6'h01;
  localparam logic [5:0] REG_MTIME    = 6'h02;
  localparam logic [5:0] REG_MTIMECMP = 6'h03;
  localparam logic [5:0] REG_SCRATCH  = 6'h04;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Byte lanes touched by an access of the given size at the given low address bits.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: lane_mask = 4'b0001 << lo;
      SZ_HALF: lane_mask = lo[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  // Replace only the masked byte lanes of old with the matching lanes of wdata.
  function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] wdata,
                                             input logic [3:0] mask);
    for (int i = 0; i < 4; i++)
      lane_merge[8*i +: 8] = mask[i] ? wdata[8*i +: 8] : old[8*i +: 8];
  endfunction

  // Pull the addressed lane out of a register word and zero- or sign-extend it.
  function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] lo, input logic uns);
    logic [31:0]        sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    sh = word >> {lo, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    case (size)
      SZ_BYTE: lane_extract = uns ? {24'b0, sh[7:0]}  : 32'(b);
      SZ_HALF: lane_extract = uns ? {16'b0, sh[15:0]} : 32'(h);
      default: lane_extract = word;
    endcase
  endfunction

  logic          in_win, aligned, acc_ok, wr_ok;
  logic [5:0]    reg_sel;
  logic [3:0]    wmask;
  logic [31:0]   wdata;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          full, empty, push_req, push, pop;

  logic [31:0]   mtime_q, mtime_d, mtimecmp_q, mtimecmp_d, scratch_q, scratch_d;
  logic [31:0]   status, rd_word;

  assign in_win  = (address_i[31:8] == BASE[31:8]);
  assign reg_sel = address_i[7:2];
  assign wmask   = lane_mask(size_i, address_i[1:0]);
  assign acc_ok  = in_win && aligned;
  assign wr_ok   = wr_enable_i && acc_ok;

  // Alignment/size legality and lane-replicated store data.
  always_comb begin
    aligned = 1'b0;
    wdata   = data_i;
    case (size_i)
      SZ_BYTE: begin aligned = 1'b1;                     wdata = {4{data_i[7:0]}};  end
      SZ_HALF: begin aligned = ~address_i[0];            wdata = {2{data_i[15:0]}}; end
      SZ_WORD: begin aligned = (address_i[1:0] == 2'b00); wdata = data_i;           end
      default: begin aligned = 1'b0;                     wdata = data_i;            end
    endcase
  end

  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign push_req = wr_ok && (reg_sel == REG_TXDATA);
  assign push     = push_req && !full;
  assign pop      = !empty && tx_ready_i;

  // FIFO pointer/count/overflow next state; an overflowing push beats a clear.
  always_comb begin
    wptr_d  = push ? wptr_q + PW'(1) : wptr_q;
    rptr_d  = pop  ? rptr_q + PW'(1) : rptr_q;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q;
    if (wr_ok && (reg_sel == REG_STATUS) && data_i[2]) ovf_d = 1'b0;
    if (push_req && full)                              ovf_d = 1'b1;
  end

  // Timer and scratch next state; a store to MTIME merges over the incremented value.
  always_comb begin
    mtime_d    = mtime_q + 32'd1;
    mtimecmp_d = mtimecmp_q;
    scratch_d  = scratch_q;
    if (wr_ok) begin
      case (reg_sel)
        REG_MTIME:    mtime_d    = lane_merge(mtime_q + 32'd1, wdata, wmask);
        REG_MTIMECMP: mtimecmp_d = lane_merge(mtimecmp_q, wdata, wmask);
        REG_SCRATCH:  scratch_d  = lane_merge(scratch_q, wdata, wmask);
        default:      ;
      endcase
    end
  end

  // Control and architectural registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      mtime_q    <= 32'h0000_0000;
      mtimecmp_q <= 32'hFFFF_FFFF;
      scratch_q  <= 32'h0000_0000;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      scratch_q  <= scratch_d;
    end
  end

  // FIFO storage; contents are meaningless until the pointers say otherwise.
  always_ff @(posedge clock) begin
    if (push) mem_q[wptr_q] <= data_i[7:0];
  end

  assign status = {16'b0, 8'(count_q), 5'b0, ovf_q, empty, full};

  // Load path: select the register word, then extract the addressed lane.
  always_comb begin
    rd_word = 32'h0;
    case (reg_sel)
      REG_STATUS:   rd_word = status;
      REG_MTIME:    rd_word = mtime_q;
      REG_MTIMECMP: rd_word = mtimecmp_q;
      REG_SCRATCH:  rd_word = scratch_q;
      default:      rd_word = 32'h0;
    endcase
    output_o = acc_ok ? lane_extract(rd_word, size_i, address_i[1:0], unsigned_i) : 32'h0;
  end

  assign tx_valid_o  = !empty;
  assign tx_data_o   = mem_q[rptr_q];
  assign timer_irq_o = (mtime_q >= mtimecmp_q);

endmodule
